// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the sequence detector.
// One-word hold buffer behind a shift register gives gapless streaming.
module seq_serializer #(
  parameter int   WIDTH     = 8,
  parameter logic IDLE_BIT  = 1'b0,
  parameter bit   MSB_FIRST = 1'b1,
  parameter int   WCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_vld,
  output logic              din_rdy,
  input  logic              en,
  output logic              seq_out,
  output logic              seq_vld,
  output logic              word_done,
  output logic              busy,
  output logic [WCNT_W-1:0] word_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  sreg_q;
  logic [WIDTH-1:0]  sreg_d;
  logic [WIDTH-1:0]  hold_q;
  logic              hold_full_q;
  logic              hold_full_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic [WCNT_W-1:0] wcnt_d;
  logic              accept;
  logic              last;
  logic              load;
  logic              cur_bit;

  assign din_rdy   = !hold_full_q;
  assign accept    = din_vld && din_rdy;
  assign last      = (state_q == SHIFT) && (cnt_q == LAST);
  assign word_done = last && en;
  assign busy      = (state_q == SHIFT) || hold_full_q;
  assign word_cnt  = wcnt_q;
  assign seq_vld   = (state_q == SHIFT);
  assign cur_bit   = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign seq_out   = seq_vld ? cur_bit : IDLE_BIT;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hold_full_q && en) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          if (cnt_q == LAST) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
            if (hold_full_q) load = 1'b1;
            else state_d = IDLE;
          end else begin
            sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // load needs hold_full, accept needs !hold_full: never both
    if (load) begin
      sreg_d      = hold_q;
      cnt_d       = '0;
      hold_full_d = 1'b0;
    end
    if (accept) hold_full_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      hold_full_q <= hold_full_d;
      if (accept) hold_q <= din;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench for seq_serializer: default, LSB-first and 4-bit
// word counter instances share one stimulus stream.
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_vld = 1'b0;
  logic       en = 1'b1;

  logic        din_rdy, seq_out, seq_vld, word_done, busy;
  logic [15:0] word_cnt;
  logic        l_rdy, l_out, l_vld, l_done, l_busy;
  logic [15:0] l_cnt;
  logic        w_rdy, w_out, w_vld, w_done, w_busy;
  logic [3:0]  w_cnt;

  int n_checks = 0;
  int n_fail = 0;
  logic q_msb[$];
  logic q_lsb[$];

  always #5 clk = ~clk;

  seq_serializer u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .din_rdy(din_rdy), .en(en), .seq_out(seq_out),
    .seq_vld(seq_vld), .word_done(word_done), .busy(busy),
    .word_cnt(word_cnt)
  );

  seq_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .din_rdy(l_rdy), .en(en), .seq_out(l_out),
    .seq_vld(l_vld), .word_done(l_done), .busy(l_busy),
    .word_cnt(l_cnt)
  );

  seq_serializer #(.WCNT_W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .din_rdy(w_rdy), .en(en), .seq_out(w_out),
    .seq_vld(w_vld), .word_done(w_done), .busy(w_busy),
    .word_cnt(w_cnt)
  );

  // push expected bit order on every accept
  always @(posedge clk) begin
    if (rst_n && din_vld && din_rdy) begin
      for (int b = 7; b >= 0; b--) q_msb.push_back(din[b]);
      for (int b = 0; b < 8; b++) q_lsb.push_back(din[b]);
    end
  end

  // a bit stays on the line until an edge with en=1
  always @(negedge clk) begin
    if (rst_n && seq_vld) begin
      n_checks++;
      if (q_msb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_msb: unexpected bit %b, queue empty", seq_out);
      end else begin
        if (seq_out !== q_msb[0]) begin
          n_fail++;
          $display("FAIL sb_msb: got %b want %b", seq_out, q_msb[0]);
        end
        if (en) void'(q_msb.pop_front());
      end
    end
    if (rst_n && l_vld) begin
      n_checks++;
      if (q_lsb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_lsb: unexpected bit %b, queue empty", l_out);
      end else begin
        if (l_out !== q_lsb[0]) begin
          n_fail++;
          $display("FAIL sb_lsb: got %b want %b", l_out, q_lsb[0]);
        end
        if (en) void'(q_lsb.pop_front());
      end
    end
  end

  task automatic do_reset();
    din_vld = 1'b0;
    en = 1'b1;
    #2 rst_n = 1'b0;
    q_msb.delete();
    q_lsb.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] w);
    bit ok = 1'b0;
    din = w;
    din_vld = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (din_rdy) begin
        @(posedge clk);
        #2 ok = 1'b1;
      end
    end
    din_vld = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: word %h not accepted", w);
    end
  endtask

  task automatic test_reset();
    din_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks += 6;
    if (din_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rdy: got %b want 1", din_rdy); end
    if (seq_out !== 1'b0) begin n_fail++; $display("FAIL rst_out: got %b want 0", seq_out); end
    if (seq_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b want 0", seq_vld); end
    if (word_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", word_done); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", word_cnt); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic ev, ed;
    do_reset();
    send_word(8'hB4);
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      ev = (i >= 1 && i <= 8);
      ed = (i == 8);
      n_checks += 2;
      if (seq_vld !== ev) begin n_fail++; $display("FAIL single_vld[%0d]: got %b want %b", i, seq_vld, ev); end
      if (word_done !== ed) begin n_fail++; $display("FAIL single_done[%0d]: got %b want %b", i, word_done, ed); end
    end
    n_checks++;
    if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", word_cnt); end
  endtask

  task automatic test_back_to_back();
    logic ev, ed, er;
    do_reset();
    send_word(8'hB4);
    din = 8'h5A;
    din_vld = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      @(negedge clk);
      ev = (i >= 1 && i <= 16);
      ed = (i == 8 || i == 16);
      er = (i == 1 || i >= 9);
      n_checks += 3;
      if (seq_vld !== ev) begin n_fail++; $display("FAIL b2b_vld[%0d]: got %b want %b", i, seq_vld, ev); end
      if (word_done !== ed) begin n_fail++; $display("FAIL b2b_done[%0d]: got %b want %b", i, word_done, ed); end
      if (din_rdy !== er) begin n_fail++; $display("FAIL b2b_rdy[%0d]: got %b want %b", i, din_rdy, er); end
      if (i == 2) din_vld = 1'b0;
    end
    n_checks++;
    if (word_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 2", word_cnt); end
  endtask

  task automatic test_stall();
    logic ev, ed;
    logic [15:0] ec;
    do_reset();
    send_word(8'hB4);
    for (int i = 0; i <= 12; i++) begin
      en = !(i >= 3 && i <= 5);
      @(negedge clk);
      ev = (i >= 1 && i <= 11);
      ed = (i == 11);
      ec = (i == 12) ? 16'd1 : 16'd0;
      n_checks += 3;
      if (seq_vld !== ev) begin n_fail++; $display("FAIL stall_vld[%0d]: got %b want %b", i, seq_vld, ev); end
      if (word_done !== ed) begin n_fail++; $display("FAIL stall_done[%0d]: got %b want %b", i, word_done, ed); end
      if (word_cnt !== ec) begin n_fail++; $display("FAIL stall_cnt[%0d]: got %0d want %0d", i, word_cnt, ec); end
      if (i >= 3 && i <= 6) begin
        n_checks++;
        if (seq_out !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: got %b want 1", i, seq_out); end
      end
      @(posedge clk);
      #2;
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic ev;
    send_word(8'hB4);
    send_word(8'h5A);
    repeat (3) @(negedge clk);
    n_checks += 2;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
    if (din_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_rdy_pre: got %b want 0", din_rdy); end
    #2 rst_n = 1'b0;
    q_msb.delete();
    q_lsb.delete();
    #1;
    n_checks += 5;
    if (seq_vld !== 1'b0) begin n_fail++; $display("FAIL mid_vld: got %b want 0", seq_vld); end
    if (seq_out !== 1'b0) begin n_fail++; $display("FAIL mid_out: got %b want 0", seq_out); end
    if (din_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_rdy: got %b want 1", din_rdy); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d want 0", word_cnt); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    send_word(8'hB4);
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      ev = (i >= 1 && i <= 8);
      n_checks++;
      if (seq_vld !== ev) begin n_fail++; $display("FAIL mid_post_vld[%0d]: got %b want %b", i, seq_vld, ev); end
    end
    n_checks++;
    if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_post_cnt: got %0d want 1", word_cnt); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_bits = 8'hB4;
    do_reset();
    send_word(8'h2D);
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        n_checks += 2;
        if (l_vld !== 1'b1) begin n_fail++; $display("FAIL lsb_vld[%0d]: got %b want 1", i, l_vld); end
        if (l_out !== exp_bits[8-i]) begin
          n_fail++;
          $display("FAIL lsb_bit[%0d]: got %b want %b", i, l_out, exp_bits[8-i]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    fork
      begin
        for (int w = 0; w < 17; w++) send_word(8'(w * 37 + 11));
      end
      begin
        for (int c = 0; c < 600 && n < 17; c++) begin
          @(negedge clk);
          if (w_done) begin
            n++;
            @(posedge clk);
            #1;
            n_checks++;
            if (w_cnt !== 4'(n)) begin
              n_fail++;
              $display("FAIL wrap_cnt[%0d]: got %0d want %0d", n, w_cnt, 4'(n));
            end
          end
        end
      end
    join
    n_checks++;
    if (n != 17) begin n_fail++; $display("FAIL wrap_words: got %0d want 17", n); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (word_cnt !== 16'd17) begin n_fail++; $display("FAIL wrap_cnt16: got %0d want 17", word_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_lsb_first();
    test_wrap();
    repeat (12) @(negedge clk);
    n_checks++;
    if (q_msb.size() != 0 || q_lsb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d/%0d bits left want 0", q_msb.size(), q_lsb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Upstream feeder for the serial sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock, MSB-first by default, on seq_out.
- A one-word holding buffer lets back-to-back words stream with no idle bits between them.
- Also reports per-word completion and a running count of completed words.

Parameters:
- WIDTH, 8, bits per input word; legal range 2..32.
- IDLE_BIT, 1'b0, value driven on seq_out when no word is being shifted.
- MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.
- WCNT_W, 16, width of the completed-word counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  parallel word to serialize.
- din_vld  input  1  din is valid.
- din_rdy  output  1  hold buffer can accept a word.
- en  input  1  shift enable; low stalls the serializer.
- seq_out  output  1  serial bit stream; connects to the detector's seq_in.
- seq_vld  output  1  seq_out carries a data bit this cycle.
- word_done  output  1  the last bit of the current word is on seq_out this cycle and en=1.
- busy  output  1  shifter active or hold buffer full.
- word_cnt  output  WCNT_W  number of completed words; wraps modulo 2^WCNT_W.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0, all of the following are forced:
  - state=IDLE; shift register, bit counter, hold buffer and hold_full cleared; word_cnt=0.
  - Outputs: din_rdy=1, seq_out=IDLE_BIT, seq_vld=0, word_done=0, busy=0.
- Reset mid-word discards both the partial word and the buffered word. The first post-reset word starts at its first bit.
- Handshake:
  - din_rdy = !hold_full, decoded from registers only, never from din_vld.
  - Transfer occurs on a rising edge with din_vld=1 && din_rdy=1; din is captured into hold and hold_full sets.
  - din_vld=1 with din_rdy=0 is stalled. No data is lost, and the producer holds din.
  - There is no bypass: a word cannot be accepted in the same edge that frees the hold buffer. din_rdy rises the cycle after the hold buffer unloads.
- State machine, two states:
  - IDLE: seq_vld=0, seq_out=IDLE_BIT. If hold_full && en, load hold into the shift register, clear hold_full, set cnt=0, go to SHIFT.
  - SHIFT: seq_vld=1, seq_out=current bit (MSB of the shift register if MSB_FIRST, else LSB). On each edge with en=1:
    - If cnt<WIDTH-1: shift by one and increment cnt.
    - If cnt==WIDTH-1 (last bit):
      - word_cnt increments.
      - If hold_full, load hold, clear hold_full, cnt=0, stay in SHIFT (gapless).
      - Otherwise go to IDLE.
  - en=0 freezes state, cnt, shift register, seq_out and word_cnt. The hold buffer can still accept a word.
- Latency: a word accepted at edge k drives its first bit on seq_out from edge k+1 when the shifter is idle and en=1. The first bit occupies cycle k+1..k+2.
- Throughput: one word per WIDTH cycles sustained. No gap bits are inserted while the producer keeps the hold buffer full.
- word_done is combinational: SHIFT && cnt==WIDTH-1 && en. It lasts exactly one cycle per completed word unless en stalls.
- busy = (state==SHIFT) || hold_full.
- word_cnt wraps from all-ones to 0 with no flag.
- The bit counter is $clog2(WIDTH) wide; it never exceeds WIDTH-1.

Test Plan:
- Reset, then a single word din=8'hB4 (1011_0100) with en=1 -> seq_out bits 1,0,1,1,0,1,0,0 on consecutive cycles starting one cycle after the accept edge. seq_vld high for exactly 8 cycles; word_done high on the 8th; word_cnt=1. When driving the detector, its flag asserts the cycle after the 7th bit.
- Back-to-back 8'hB4, 8'h5A with din_vld held high -> 16 contiguous seq_vld cycles with no IDLE_BIT gap. din_rdy low while hold_full, high again the cycle after each hold unload; word_cnt=2.
- en deasserted for 3 cycles after bit 3 of 8'hB4 -> seq_out holds bit 3 value (1) for 4 total cycles, then resumes. word_done and word_cnt delayed by exactly 3 cycles.
- rst_n pulsed low mid-word (after bit 4) with a second word buffered -> immediately seq_vld=0, seq_out=0, din_rdy=1, busy=0, word_cnt=0. The next accepted 8'hB4 serializes from its first bit.
- MSB_FIRST=0, din=8'h2D -> seq_out bits 1,0,1,1,0,1,0,0 (LSB first).
- WCNT_W=4: send 17 words -> word_cnt reads 15 after word 15, 0 after word 16, 1 after word 17.
